// File: rtl/alu4bit_pkg.sv
// Shared types for the 4-bit ALU sequencer: widths, opcodes, FSM states,
// request payload and the reference ALU function used by the optional scoreboard.
package alu4bit_pkg;

   localparam int DATA_W = 4;
   localparam int OP_W   = 3;
   localparam int TAG_W  = 2;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOR = 3'd5,
      OP_SLT = 3'd6,
      OP_SLL = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  tag;
   } req_t;

   // Arithmetic wraps modulo 16, SLT is unsigned, SLL uses only b[2:0].
   function automatic logic [DATA_W-1:0] alu_golden(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic [OP_W-1:0]   op);
      logic [DATA_W-1:0] r;
      r = '0;
      case (alu_op_t'(op))
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NOR:  r = ~(a | b);
         OP_SLT:  r = {{(DATA_W-1){1'b0}}, (a < b)};
         OP_SLL:  r = a << b[2:0];
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu4bit_seq_fifo.sv
// Request FIFO for the ALU sequencer; DEPTH must be a power of two >= 2.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alu4bit_seq_fifo
   import alu4bit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  req_t push_data,
   input  logic pop,
   output req_t head,
   output logic full,
   output logic empty
);

   localparam int PW = $clog2(DEPTH);

   req_t        mem [DEPTH];
   logic [PW:0] wr_ptr_q;
   logic [PW:0] rd_ptr_q;
   logic        push_ok;
   logic        pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr_q[PW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: entries are only read between matching pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/alu4bit_sequencer.sv
// Queues ALU requests, issues them one at a time to an external ALU and returns
// responses in order. Define ALU_SEQ_SCOREBOARD_EN to add the golden-result checker.
module alu4bit_sequencer
   import alu4bit_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [OP_W-1:0]   req_op,
   input  logic [TAG_W-1:0]  req_tag,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_c,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_c,
   output logic [OP_W-1:0]   rsp_op,
   output logic [TAG_W-1:0]  rsp_tag,
`ifdef ALU_SEQ_SCOREBOARD_EN
   output logic              rsp_mismatch,
   output logic [7:0]        err_count,
`endif
   output seq_state_t        dbg_state
);

   // Handshakes: a beat transfers on a rising edge where valid && ready; the
   // sender holds valid and payload stable until then, ready may depend on state.

   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   seq_state_t        state_q, state_d;
   logic              ready_en_q;
   logic [CW-1:0]     wait_cnt_q;
   logic              wait_last;
   logic [DATA_W-1:0] alu_a_q, alu_b_q;
   logic [OP_W-1:0]   alu_op_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DATA_W-1:0] rsp_c_q;

   req_t              push_data;
   req_t              head;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

   assign push_data = '{a: req_a, b: req_b, op: req_op, tag: req_tag};
   // ready_en_q keeps req_ready low through reset and the first edge after release.
   assign req_ready = ready_en_q && !fifo_full;
   assign fifo_push = req_valid && req_ready;
   assign fifo_pop  = (state_q == ST_ISSUE);

   alu4bit_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (fifo_pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign wait_last = (wait_cnt_q == CW'(ALU_LAT - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (wait_last) state_d = ST_RESP;
         ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ready_en_q <= 1'b0;
         wait_cnt_q <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tag_q      <= '0;
         rsp_c_q    <= '0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
         if (state_q == ST_ISSUE) begin
            alu_a_q    <= head.a;
            alu_b_q    <= head.b;
            alu_op_q   <= head.op;
            tag_q      <= head.tag;
            wait_cnt_q <= '0;
         end
         if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            if (wait_last) rsp_c_q <= alu_c;
         end
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_c     = rsp_c_q;
   assign rsp_op    = alu_op_q;
   assign rsp_tag   = tag_q;
   assign dbg_state = state_q;

`ifdef ALU_SEQ_SCOREBOARD_EN
   logic [DATA_W-1:0] golden;
   logic [7:0]        err_count_q;

   assign golden       = alu_golden(alu_a_q, alu_b_q, alu_op_q);
   assign rsp_mismatch = rsp_valid && (rsp_c_q != golden);
   assign err_count    = err_count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_count_q <= '0;
      end else if (rsp_valid && rsp_ready && rsp_mismatch && (err_count_q != 8'hFF)) begin
         err_count_q <= err_count_q + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu4bit_sequencer.sv
// Directed bench for alu4bit_sequencer: the bench plays the external ALU and
// checks responses against hand-computed results.
module tb_alu4bit_sequencer;
   import alu4bit_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [3:0] req_a = '0, req_b = '0;
   logic [2:0] req_op = '0;
   logic [1:0] req_tag = '0;
   logic [3:0] alu_a, alu_b, alu_c;
   logic [2:0] alu_op;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_c;
   logic [2:0] rsp_op;
   logic [1:0] rsp_tag;
`ifdef ALU_SEQ_SCOREBOARD_EN
   logic       rsp_mismatch;
   logic [7:0] err_count;
`endif
   seq_state_t dbg_state;

   logic       zero_alu = 1'b0;
   int         checks = 0;
   int         failures = 0;
   int         cyc_cnt = 0;
   logic [5:0] exp_q[$];

   alu4bit_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_op       (req_op),
      .req_tag      (req_tag),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_c        (alu_c),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_c        (rsp_c),
      .rsp_op       (rsp_op),
      .rsp_tag      (rsp_tag),
`ifdef ALU_SEQ_SCOREBOARD_EN
      .rsp_mismatch (rsp_mismatch),
      .err_count    (err_count),
`endif
      .dbg_state    (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // external ALU stand-in; zero_alu models a broken ALU
   always_comb begin
      alu_c = '0;
      if (!zero_alu) begin
         case (alu_op)
            3'd0: alu_c = alu_a + alu_b;
            3'd1: alu_c = alu_a - alu_b;
            3'd2: alu_c = alu_a & alu_b;
            3'd3: alu_c = alu_a | alu_b;
            3'd4: alu_c = alu_a ^ alu_b;
            3'd5: alu_c = ~(alu_a | alu_b);
            3'd6: alu_c = (alu_a < alu_b) ? 4'd1 : 4'd0;
            3'd7: alu_c = alu_a << alu_b[2:0];
            default: alu_c = '0;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // driver: present a request and hold it until accepted
   task automatic push(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [1:0] tag);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_a = a; req_b = b; req_op = op; req_tag = tag;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("push_accept", req_ready, 1'b1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // driver: wait for a response and complete its handshake
   task automatic get_rsp(output logic [3:0] c, output logic [1:0] tag);
      int n = 0;
      rsp_ready = 1'b1;
      while (!rsp_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rsp_arrive", rsp_valid, 1'b1);
      c = rsp_c;
      tag = rsp_tag;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [1:0] tag, input logic [3:0] exp_c);
      logic [3:0] c;
      logic [1:0] t;
      push(a, b, op, tag);
      get_rsp(c, t);
      check(name, c, exp_c);
      check({name, "_tag"}, t, tag);
   endtask

   initial begin
      int         cyc;
      int         t_first;
      int         seen;
      logic [3:0] c;
      logic [1:0] t;
      logic [5:0] e;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_alu", {alu_a, alu_b, alu_op}, 11'd0);
      check("rst_rsp", {rsp_c, rsp_op, rsp_tag}, 9'd0);
      check("rst_state", dbg_state, ST_IDLE);
`ifdef ALU_SEQ_SCOREBOARD_EN
      check("rst_err_count", err_count, 8'd0);
      check("rst_mismatch", rsp_mismatch, 1'b0);
`endif
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_release", req_ready, 1'b1);

      // single ADD with latency measurement
      rsp_ready = 1'b1;
      push(4'd3, 4'd5, OP_ADD, 2'd1);
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 2) begin
            check("wait_alu_ab", {alu_a, alu_b, alu_op}, {4'd3, 4'd5, 3'd0});
            check("wait_state", dbg_state, ST_WAIT);
         end
      end
      check("add_latency", cyc, 3);
      check("add_rsp_c", rsp_c, 4'd8);
      check("add_rsp_tag", rsp_tag, 2'd1);
      check("add_rsp_op", rsp_op, 3'd0);
`ifdef ALU_SEQ_SCOREBOARD_EN
      check("add_mismatch", rsp_mismatch, 1'b0);
`endif
      @(posedge clk);
      #1;
      check("add_rsp_done", rsp_valid, 1'b0);
      rsp_ready = 1'b0;

      // opcode coverage and boundary results
      run_op("sll", 4'b0011, 4'd2, OP_SLL, 2'd2, 4'b1100);
      run_op("slt_true", 4'd2, 4'd9, OP_SLT, 2'd3, 4'd1);
      run_op("slt_false", 4'd9, 4'd2, OP_SLT, 2'd0, 4'd0);
      run_op("sub_wrap", 4'd0, 4'd1, OP_SUB, 2'd1, 4'hF);
      run_op("add_wrap", 4'd9, 4'd8, OP_ADD, 2'd2, 4'd1);
      run_op("and", 4'hC, 4'hA, OP_AND, 2'd3, 4'h8);
      run_op("or", 4'h5, 4'hA, OP_OR, 2'd0, 4'hF);
      run_op("xor", 4'hF, 4'h5, OP_XOR, 2'd1, 4'hA);
      run_op("nor", 4'h3, 4'h4, OP_NOR, 2'd2, 4'h8);
      run_op("sll_b_high", 4'b0001, 4'b1011, OP_SLL, 2'd3, 4'b1000);

      // back-to-back fill with response stalled
      rsp_ready = 1'b0;
      push(4'd1, 4'd2, OP_ADD, 2'd0); exp_q.push_back({2'd0, 4'd3});
      t_first = cyc_cnt;
      push(4'd7, 4'd2, OP_SUB, 2'd1); exp_q.push_back({2'd1, 4'd5});
      push(4'hF, 4'd3, OP_AND, 2'd2); exp_q.push_back({2'd2, 4'd3});
      push(4'd8, 4'd1, OP_OR,  2'd3); exp_q.push_back({2'd3, 4'd9});
      push(4'd6, 4'd3, OP_XOR, 2'd0); exp_q.push_back({2'd0, 4'd5});
      check("fill_back_to_back", cyc_cnt - t_first, 4);
      check("full_ready_low", req_ready, 1'b0);

      // hold in RESP for 10 cycles: outputs frozen, no new issue
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("resp_hold", {rsp_valid, rsp_c, rsp_tag, alu_a, alu_b, alu_op, req_ready},
               {1'b1, 4'd3, 2'd0, 4'd1, 4'd2, 3'd0, 1'b0});
      end
      check("resp_hold_state", dbg_state, ST_RESP);

      // drain: scoreboard compares order and results
      for (int i = 0; i < 5; i++) begin
         get_rsp(c, t);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3F;
         check("drain_order", {t, c}, e);
      end

`ifdef ALU_SEQ_SCOREBOARD_EN
      // broken ALU produces a mismatch
      zero_alu = 1'b1;
      push(4'd1, 4'd1, OP_ADD, 2'd2);
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("bad_rsp_c", rsp_c, 4'd0);
      check("bad_mismatch", rsp_mismatch, 1'b1);
      check("bad_err_before", err_count, 8'd0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("bad_err_after", err_count, 8'd1);
      zero_alu = 1'b0;
      run_op("good_after_bad", 4'd2, 4'd2, OP_ADD, 2'd3, 4'd4);
      check("err_count_hold", err_count, 8'd1);
`endif

      // reset during WAIT with two queued
      rsp_ready = 1'b0;
      push(4'd6, 4'd3, OP_ADD, 2'd1);
      push(4'd1, 4'd1, OP_ADD, 2'd2);
      push(4'd2, 4'd2, OP_ADD, 2'd3);
      check("pre_reset_state", dbg_state, ST_WAIT);
      check("pre_reset_alu", {alu_a, alu_b}, {4'd6, 4'd3});
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_state", dbg_state, ST_IDLE);
      check("mid_rst_outs", {rsp_valid, req_ready, alu_a, alu_b, alu_op, rsp_c, rsp_tag},
            18'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_ready", req_ready, 1'b1);
      rsp_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid || dbg_state != ST_IDLE) seen++;
      end
      check("no_rsp_after_reset", seen, 0);
      rsp_ready = 1'b0;
      run_op("after_reset", 4'd4, 4'd5, OP_ADD, 2'd0, 4'd9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
